spi_lcd_slave: RTL and testbench
================================

SPI_LCD_SLAVE -- requirements
Module: spi_lcd_slave

Interface
REQ-001 Parameter FIFO_DEPTH, default 4, number of received-byte entries; SHALL be a power of 2, at least 2.
REQ-002 Parameter SYNC_STAGES, default 2, number of synchronizer flops on each SPI pin input.
REQ-003 Port gclk  in  1  single system clock; the block SHALL use no other clock.
REQ-004 Port greset  in  1  reset, asynchronous, active-high.
REQ-005 Port sclk_in  in  1  SPI clock from master; mode 0 (CPOL=0, CPHA=0).
REQ-006 Port nss_in  in  1  slave select, active-low.
REQ-007 Port mosi_in  in  1  serial data from master, MSB first.
REQ-008 Port dc_in  in  1  LCD data/command select from GPIO (1=data, 0=command).
REQ-009 Port miso_out  out  1  serial status to master.
REQ-010 Port rx_data  out  8  head-of-FIFO byte.
REQ-011 Port rx_dc  out  1  dc_in value captured with rx_data.
REQ-012 Port rx_valid  out  1  FIFO non-empty.
REQ-013 Port rx_ready  in  1  consumer accept; a pop occurs when rx_valid and rx_ready are both high.
REQ-014 Port fifo_level  out  $clog2(FIFO_DEPTH)+1  current entry count.
REQ-015 Port overflow  out  1  sticky, byte dropped because FIFO was full.
REQ-016 Port overflow_clr  in  1  single-cycle clear of overflow.
REQ-017 Port frame_err  out  1  one-cycle pulse when nss_in rises with a partial byte.

Function
REQ-018 sclk_in, nss_in, mosi_in and dc_in SHALL each pass through SYNC_STAGES flops; all edge detection SHALL use the synchronized values.
REQ-019 The block SHALL support sclk_in frequencies up to gclk/8; faster sclk_in is out of spec.
REQ-020 FSM states: IDLE (nss high) and SHIFT (nss low); IDLE->SHIFT on the synced nss falling edge, SHIFT->IDLE on the synced nss rising edge.
REQ-021 In SHIFT, each synced sclk rising edge SHALL shift mosi into an 8-bit register and increment a 3-bit bit counter.
REQ-022 On the 8th rising edge, the block SHALL write {dc, byte} into the FIFO on that gclk edge, wrap the bit counter to 0 and stay in SHIFT; rx_valid SHALL be high on the next cycle.
REQ-023 Total latency from the 8th pin sclk rise to rx_valid SHALL be SYNC_STAGES+2 gclk cycles.
REQ-024 When nss rises with the bit counter nonzero, the partial byte SHALL be discarded, the counter cleared, and frame_err pulsed for one cycle.
REQ-025 Push when full without a same-cycle pop: the byte SHALL be dropped and overflow set; the FIFO contents SHALL be unchanged.
REQ-026 Push and pop in the same cycle while full: both SHALL take effect and overflow SHALL NOT be set.
REQ-027 Push and pop in the same cycle while empty: the pop SHALL be ignored, because rx_valid is low.
REQ-028 overflow_clr and a new overflow in the same cycle: set SHALL win.
REQ-029 rx_data and rx_dc SHALL remain stable while rx_valid is high and rx_ready is low.
REQ-030 The pointers SHALL wrap modulo FIFO_DEPTH; fifo_level SHALL reach FIFO_DEPTH when full.

Reset
REQ-031 greset SHALL asynchronously force the following: state IDLE, bit counter 0, FIFO empty, rx_valid=0, rx_data=0, rx_dc=0, fifo_level=0, overflow=0, frame_err=0, miso_out=0, synchronizers to idle levels (nss 1, sclk 0).
REQ-032 Reset asserted mid-byte SHALL lose the partial byte; after release, reception SHALL resume only after a fresh nss falling edge.

Configuration
REQ-033 With SPI_LCD_SLAVE_MISO_EN defined, the block SHALL drive a status byte {overflow, 3'b000, fifo_level zero-extended to 4 bits} on miso_out.
REQ-034 The status byte SHALL be loaded on the synced nss fall and at each byte boundary, and shifted MSB first on synced sclk falling edges.
REQ-035 Without SPI_LCD_SLAVE_MISO_EN, miso_out SHALL be tied 0 and no TX shift register SHALL exist.

Structure
REQ-036 A shared package SHALL hold the FSM state typedef (IDLE, SHIFT), the FIFO entry width constant (9) and the status-byte field positions.
REQ-037 The FIFO SHALL be the sub-module spi_lcd_rx_fifo, with push, pop, full, empty and level.

Verification
REQ-038 Send 0xA5 with dc=1, rx_ready=1 -> rx_data=0xA5, rx_dc=1, rx_valid high for exactly 1 cycle, SYNC_STAGES+2 cycles after the 8th sclk rise.
REQ-039 rx_ready=0, send 5 bytes 0x01..0x05 -> fifo_level=4, overflow=1; pops yield 0x01..0x04; overflow_clr then returns overflow to 0.
REQ-040 Raise nss after 5 bits -> frame_err pulses once, fifo_level unchanged; the next full byte 0x3C is received correctly.
REQ-041 FIFO full with a push and a pop in the same cycle -> level stays 4, overflow stays 0, order preserved.
REQ-042 greset asserted after 4 bits -> all outputs 0; after release, nss low and byte 0x81 received intact.
REQ-043 With SPI_LCD_SLAVE_MISO_EN, level=2 and overflow=1 -> master reads 0x82.

Source files
------------

// File: rtl/spi_lcd_slave_pkg.sv
// Shared types and constants for the SPI LCD slave: FSM states, FIFO entry layout
// and the status-byte layout used when SPI_LCD_SLAVE_MISO_EN is defined.
package spi_lcd_slave_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  localparam int ENTRY_W      = 9;
  localparam int ENTRY_DC_BIT = 8;

  localparam int STAT_OVF_BIT = 7;
  localparam int STAT_LVL_MSB = 3;
  localparam int STAT_LVL_LSB = 0;

  function automatic logic [7:0] status_byte(input logic ovf, input logic [3:0] lvl);
    logic [7:0] s;
    s = '0;
    s[STAT_OVF_BIT] = ovf;
    s[STAT_LVL_MSB:STAT_LVL_LSB] = lvl;
    return s;
  endfunction

endpackage

// File: rtl/spi_lcd_rx_fifo.sv
// Receive FIFO for the SPI LCD slave: power-of-2 depth, wrapping pointers, level count.
// A pop on empty is ignored; a push on full is ignored unless a pop frees a slot that cycle.
module spi_lcd_rx_fifo
  import spi_lcd_slave_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = ENTRY_W
) (
  input  logic                     gclk,
  input  logic                     greset,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_wr_data,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_rd_data,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_level
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] LVL_FULL = DEPTH[AW:0];

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_level;
  logic             w_do_pop;
  logic             w_do_push;

  assign o_full    = (r_level == LVL_FULL);
  assign o_empty   = (r_level == '0);
  assign o_level   = r_level;
  assign o_rd_data = r_mem[r_rd_ptr];

  assign w_do_pop  = i_pop & ~o_empty;
  assign w_do_push = i_push & (~o_full | w_do_pop);

  always_ff @(posedge gclk or posedge greset) begin
    if (greset) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_do_push) begin
        r_mem[r_wr_ptr] <= i_wr_data;
        r_wr_ptr        <= r_wr_ptr + AW'(1);
      end
      if (w_do_pop) r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_level <= r_level + (AW+1)'(1);
        2'b01:   r_level <= r_level - (AW+1)'(1);
        default: r_level <= r_level;
      endcase
    end
  end

endmodule

// File: rtl/spi_lcd_slave.sv
// SPI mode-0 slave that collects LCD command/data bytes into a FIFO, oversampled on gclk.
// Define SPI_LCD_SLAVE_MISO_EN to return a status byte on miso_out; otherwise miso_out is 0.
//
// state    | meaning
// ST_IDLE  | nss high, waiting for a synced nss falling edge
// ST_SHIFT | nss low, shifting mosi on synced sclk rising edges
module spi_lcd_slave
  import spi_lcd_slave_pkg::*;
#(
  parameter int FIFO_DEPTH  = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                          gclk,
  input  logic                          greset,
  input  logic                          sclk_in,
  input  logic                          nss_in,
  input  logic                          mosi_in,
  input  logic                          dc_in,
  output logic                          miso_out,
  output logic [7:0]                    rx_data,
  output logic                          rx_dc,
  output logic                          rx_valid,
  input  logic                          rx_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          overflow,
  input  logic                          overflow_clr,
  output logic                          frame_err
);

  // synchronizer lanes {dc, mosi, nss, sclk}; idle is nss high, everything else low
  localparam logic [3:0] SYNC_IDLE = 4'b0010;

  logic [3:0]          r_sync [SYNC_STAGES];
  logic [3:0]          w_sync;
  logic                w_sclk_s;
  logic                w_nss_s;
  logic                w_mosi_s;
  logic                w_dc_s;

  logic                r_sclk_d;
  logic                r_nss_d;
  logic                r_sclk_rise;
  logic                r_nss_rise;
  logic                r_nss_fall;
  logic                r_mosi_q;
  logic                r_dc_q;

  state_t              r_state;
  state_t              w_state_nx;
  logic [2:0]          r_bit_cnt;
  logic [2:0]          w_bit_cnt_nx;
  logic [7:0]          r_shift;
  logic [7:0]          w_shift_nx;
  logic                w_push;
  logic                w_frame_err;
  logic                r_frame_err;
  logic                r_overflow;

  logic [ENTRY_W-1:0]  w_push_entry;
  logic [ENTRY_W-1:0]  w_rd_entry;
  logic                w_full;
  logic                w_empty;
  logic                w_pop_ok;
  logic                w_drop;
  logic [$clog2(FIFO_DEPTH):0] w_level;

  assign w_sync   = r_sync[SYNC_STAGES-1];
  assign w_sclk_s = w_sync[0];
  assign w_nss_s  = w_sync[1];
  assign w_mosi_s = w_sync[2];
  assign w_dc_s   = w_sync[3];

  always_ff @(posedge gclk or posedge greset) begin
    if (greset) begin
      for (int i = 0; i < SYNC_STAGES; i++) r_sync[i] <= SYNC_IDLE;
      r_sclk_d    <= 1'b0;
      r_nss_d     <= 1'b1;
      r_sclk_rise <= 1'b0;
      r_nss_rise  <= 1'b0;
      r_nss_fall  <= 1'b0;
      r_mosi_q    <= 1'b0;
      r_dc_q      <= 1'b0;
    end else begin
      r_sync[0] <= {dc_in, mosi_in, nss_in, sclk_in};
      for (int i = 1; i < SYNC_STAGES; i++) r_sync[i] <= r_sync[i-1];
      r_sclk_d    <= w_sclk_s;
      r_nss_d     <= w_nss_s;
      r_sclk_rise <= w_sclk_s & ~r_sclk_d;
      r_nss_rise  <= w_nss_s & ~r_nss_d;
      r_nss_fall  <= ~w_nss_s & r_nss_d;
      // data lanes captured with the edge pulse so shift and push see one aligned sample
      r_mosi_q    <= w_mosi_s;
      r_dc_q      <= w_dc_s;
    end
  end

  always_ff @(posedge gclk or posedge greset) begin
    if (greset) begin
      r_state     <= ST_IDLE;
      r_bit_cnt   <= 3'd0;
      r_shift     <= 8'd0;
      r_frame_err <= 1'b0;
    end else begin
      r_state     <= w_state_nx;
      r_bit_cnt   <= w_bit_cnt_nx;
      r_shift     <= w_shift_nx;
      r_frame_err <= w_frame_err;
    end
  end

  always_comb begin
    w_state_nx   = r_state;
    w_bit_cnt_nx = r_bit_cnt;
    w_shift_nx   = r_shift;
    w_push       = 1'b0;
    w_frame_err  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (r_nss_fall) begin
          w_state_nx   = ST_SHIFT;
          w_bit_cnt_nx = 3'd0;
        end
      end
      ST_SHIFT: begin
        if (r_nss_rise) begin
          w_state_nx   = ST_IDLE;
          w_bit_cnt_nx = 3'd0;
          w_frame_err  = (r_bit_cnt != 3'd0);
        end else if (r_sclk_rise) begin
          w_shift_nx   = {r_shift[6:0], r_mosi_q};
          w_bit_cnt_nx = r_bit_cnt + 3'd1;
          w_push       = (r_bit_cnt == 3'd7);
        end
      end
      default: w_state_nx = ST_IDLE;
    endcase
  end

  assign w_push_entry = {r_dc_q, r_shift[6:0], r_mosi_q};
  assign w_pop_ok     = rx_ready & ~w_empty;
  assign w_drop       = w_push & w_full & ~w_pop_ok;

  spi_lcd_rx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .gclk      (gclk),
    .greset    (greset),
    .i_push    (w_push),
    .i_wr_data (w_push_entry),
    .i_pop     (rx_ready),
    .o_rd_data (w_rd_entry),
    .o_full    (w_full),
    .o_empty   (w_empty),
    .o_level   (w_level)
  );

  // a fresh drop wins over a same-cycle clear
  always_ff @(posedge gclk or posedge greset) begin
    if (greset)            r_overflow <= 1'b0;
    else if (w_drop)       r_overflow <= 1'b1;
    else if (overflow_clr) r_overflow <= 1'b0;
  end

  assign rx_data    = w_rd_entry[7:0];
  assign rx_dc      = w_rd_entry[ENTRY_DC_BIT];
  assign rx_valid   = ~w_empty;
  assign fifo_level = w_level;
  assign overflow   = r_overflow;
  assign frame_err  = r_frame_err;

`ifdef SPI_LCD_SLAVE_MISO_EN
  logic       r_sclk_fall;
  logic [7:0] r_tx_shift;
  logic       w_tx_load;

  assign w_tx_load = ((r_state == ST_IDLE) & r_nss_fall) | w_push;

  // the fall closing a byte sees bit count 0 and leaves the freshly loaded MSB in place
  always_ff @(posedge gclk or posedge greset) begin
    if (greset) begin
      r_sclk_fall <= 1'b0;
      r_tx_shift  <= 8'd0;
    end else begin
      r_sclk_fall <= ~w_sclk_s & r_sclk_d;
      if (w_tx_load)
        r_tx_shift <= status_byte(r_overflow, 4'(w_level));
      else if ((r_state == ST_SHIFT) && r_sclk_fall && (r_bit_cnt != 3'd0))
        r_tx_shift <= {r_tx_shift[6:0], 1'b0};
    end
  end

  assign miso_out = r_tx_shift[7];
`else
  assign miso_out = 1'b0;
`endif

endmodule

// File: tb/tb_spi_lcd_slave.sv
// Bench for spi_lcd_slave: queue-based FIFO model checked every cycle, directed cases
// with literal expectations, then randomized SPI frames with random consumer behaviour.
module tb_spi_lcd_slave;

  localparam int DEPTH = 4;
  localparam int SYNC  = 2;
  localparam int H     = 8;

  logic       gclk = 1'b0;
  logic       greset = 1'b1;
  logic       sclk_in = 1'b0;
  logic       nss_in = 1'b1;
  logic       mosi_in = 1'b0;
  logic       dc_in = 1'b0;
  logic       rx_ready = 1'b0;
  logic       overflow_clr = 1'b0;
  logic       miso_out;
  logic [7:0] rx_data;
  logic       rx_dc;
  logic       rx_valid;
  logic [2:0] fifo_level;
  logic       overflow;
  logic       frame_err;

  always #5 gclk = ~gclk;

  spi_lcd_slave #(.FIFO_DEPTH(DEPTH), .SYNC_STAGES(SYNC)) dut (
    .gclk(gclk), .greset(greset), .sclk_in(sclk_in), .nss_in(nss_in),
    .mosi_in(mosi_in), .dc_in(dc_in), .miso_out(miso_out), .rx_data(rx_data),
    .rx_dc(rx_dc), .rx_valid(rx_valid), .rx_ready(rx_ready), .fifo_level(fifo_level),
    .overflow(overflow), .overflow_clr(overflow_clr), .frame_err(frame_err)
  );

  int         n_total = 0;
  int         n_pass = 0;
  int         cyc = 0;
  logic [8:0] q[$];
  logic       m_ovf = 1'b0;
  logic       exp_ferr = 1'b0;
  bit         m_pop;
  bit         m_drop;
  logic [8:0] push_at[int];
  bit         ferr_at[int];

  int         n_valid_cyc = 0;
  int         first_valid_cyc = -1;
  int         n_ferr = 0;
  logic       was_valid = 1'b0;
  logic [8:0] last_entry = '0;

  bit         rnd_mode = 1'b0;
  int         ready_pulse_cyc = -10;
  int         bitpos = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
  endtask

  // reference model: advances on each clock edge, then outputs are compared 1ns later
  always @(posedge gclk) begin
    cyc++;
    if (greset) begin
      q.delete();
      m_ovf = 1'b0;
      exp_ferr = 1'b0;
      push_at.delete();
      ferr_at.delete();
    end else begin
      m_pop = rx_ready && (q.size() > 0);
      m_drop = 1'b0;
      exp_ferr = ferr_at.exists(cyc);
      if (m_pop) void'(q.pop_front());
      if (push_at.exists(cyc)) begin
        if (q.size() == DEPTH) begin
          m_drop = 1'b1;
          m_ovf = 1'b1;
        end else q.push_back(push_at[cyc]);
      end
      if (overflow_clr && !m_drop) m_ovf = 1'b0;
    end
    #1;
    chk("rx_valid", rx_valid, q.size() > 0);
    chk("fifo_level", fifo_level, q.size());
    chk("overflow", overflow, m_ovf);
    chk("frame_err", frame_err, exp_ferr);
    if (q.size() > 0) chk("rx_entry", {rx_dc, rx_data}, q[0]);
`ifndef SPI_LCD_SLAVE_MISO_EN
    chk("miso_tied", miso_out, 0);
`endif
    if (rx_valid) begin
      n_valid_cyc++;
      if (!was_valid) first_valid_cyc = cyc;
      last_entry = {rx_dc, rx_data};
    end
    was_valid = rx_valid;
    if (frame_err) n_ferr++;
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge gclk);
      #2;
      if (rnd_mode) begin
        rx_ready = 1'($urandom_range(0, 1));
        overflow_clr = ($urandom_range(0, 19) == 0);
      end else if (cyc == ready_pulse_cyc - 1) rx_ready = 1'b1;
      else if (cyc == ready_pulse_cyc) rx_ready = 1'b0;
    end
  endtask

  task automatic nss_fall();
    tick(1);
    nss_in = 1'b0;
    bitpos = 0;
    tick(H);
  endtask

  task automatic nss_rise();
    tick(H);
    nss_in = 1'b1;
    if (bitpos % 8 != 0) ferr_at[cyc + SYNC + 2] = 1'b1;
    tick(H);
  endtask

  task automatic send_bits(input logic [7:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      mosi_in = v[i];
      tick(H);
      sclk_in = 1'b1;
      bitpos++;
      tick(H);
      sclk_in = 1'b0;
    end
  endtask

  task automatic send_byte(input logic [7:0] d, input logic dc, input bit pop_at_push,
                           output int rc, output logic [7:0] rd);
    dc_in = dc;
    rc = 0;
    rd = '0;
    for (int i = 7; i >= 0; i--) begin
      mosi_in = d[i];
      tick(H);
      rd[i] = miso_out;
      sclk_in = 1'b1;
      bitpos++;
      if (i == 0) begin
        rc = cyc;
        push_at[cyc + SYNC + 2] = {dc, d};
        if (pop_at_push) ready_pulse_cyc = cyc + SYNC + 2;
      end
      tick(H);
      sclk_in = 1'b0;
    end
  endtask

  task automatic pop_one();
    rx_ready = 1'b1;
    tick(1);
    rx_ready = 1'b0;
  endtask

  int         rc;
  int         v0;
  int         f0;
  logic [7:0] rd;

  initial begin
    tick(3);
    chk("rst_rx_valid", rx_valid, 0);
    chk("rst_rx_data", rx_data, 0);
    chk("rst_fifo_level", fifo_level, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_frame_err", frame_err, 0);
    chk("rst_miso", miso_out, 0);
    greset = 1'b0;
    tick(4);

    // single byte with consumer always ready
    rx_ready = 1'b1;
    v0 = n_valid_cyc;
    nss_fall();
    send_byte(8'hA5, 1'b1, 1'b0, rc, rd);
    nss_rise();
    tick(4);
    chk("a5_latency", first_valid_cyc - rc, SYNC + 2);
    chk("a5_valid_len", n_valid_cyc - v0, 1);
    chk("a5_entry", last_entry, 9'h1A5);
    rx_ready = 1'b0;

    // overflow: five bytes into a four-deep FIFO
    nss_fall();
    for (int i = 1; i <= 5; i++) send_byte(8'(i), 1'b0, 1'b0, rc, rd);
    nss_rise();
    chk("ovf_level", fifo_level, 4);
    chk("ovf_flag", overflow, 1);
    for (int i = 1; i <= 4; i++) begin
      chk("ovf_pop_data", rx_data, i);
      pop_one();
    end
    overflow_clr = 1'b1;
    tick(1);
    overflow_clr = 1'b0;
    tick(1);
    chk("ovf_cleared", overflow, 0);

    // partial byte then a clean byte
    f0 = n_ferr;
    nss_fall();
    send_bits(8'h16, 5);
    nss_rise();
    tick(4);
    chk("ferr_pulses", n_ferr - f0, 1);
    chk("ferr_level", fifo_level, 0);
    nss_fall();
    send_byte(8'h3C, 1'b0, 1'b0, rc, rd);
    nss_rise();
    chk("3c_data", rx_data, 8'h3C);
    chk("3c_dc", rx_dc, 0);
    chk("3c_level", fifo_level, 1);
    pop_one();

    // push and pop in the same cycle while full
    nss_fall();
    send_byte(8'h11, 1'b1, 1'b0, rc, rd);
    send_byte(8'h22, 1'b1, 1'b0, rc, rd);
    send_byte(8'h33, 1'b1, 1'b0, rc, rd);
    send_byte(8'h44, 1'b1, 1'b0, rc, rd);
    send_byte(8'h55, 1'b1, 1'b1, rc, rd);
    nss_rise();
    chk("full_pp_level", fifo_level, 4);
    chk("full_pp_ovf", overflow, 0);
    for (int i = 2; i <= 5; i++) begin
      chk("full_pp_order", rx_data, 8'(i * 8'h11));
      pop_one();
    end

    // reset mid-byte with entries queued
    nss_fall();
    send_byte(8'h5A, 1'b1, 1'b0, rc, rd);
    send_byte(8'h6B, 1'b0, 1'b0, rc, rd);
    send_bits(8'h0F, 4);
    greset = 1'b1;
    nss_in = 1'b1;
    bitpos = 0;
    tick(2);
    chk("mid_rst_valid", rx_valid, 0);
    chk("mid_rst_data", rx_data, 0);
    chk("mid_rst_dc", rx_dc, 0);
    chk("mid_rst_level", fifo_level, 0);
    chk("mid_rst_ovf", overflow, 0);
    chk("mid_rst_ferr", frame_err, 0);
    chk("mid_rst_miso", miso_out, 0);
    greset = 1'b0;
    tick(4);
    nss_fall();
    send_byte(8'h81, 1'b1, 1'b0, rc, rd);
    nss_rise();
    chk("81_data", rx_data, 8'h81);
    chk("81_dc", rx_dc, 1);
    chk("81_level", fifo_level, 1);
    pop_one();

`ifdef SPI_LCD_SLAVE_MISO_EN
    nss_fall();
    for (int i = 0; i < 5; i++) send_byte(8'hC0 + 8'(i), 1'b0, 1'b0, rc, rd);
    nss_rise();
    pop_one();
    pop_one();
    nss_fall();
    send_byte(8'h00, 1'b0, 1'b0, rc, rd);
    nss_rise();
    chk("miso_status", rd, 8'h82);
    rx_ready = 1'b1;
    tick(8);
    rx_ready = 1'b0;
    overflow_clr = 1'b1;
    tick(1);
    overflow_clr = 1'b0;
`endif

    // randomized frames with random consumer and clears
    rnd_mode = 1'b1;
    repeat (30) begin
      nss_fall();
      repeat ($urandom_range(0, 4))
        send_byte(8'($urandom), 1'($urandom_range(0, 1)), 1'b0, rc, rd);
      if ($urandom_range(0, 2) == 0) send_bits(8'($urandom), $urandom_range(1, 7));
      nss_rise();
      tick($urandom_range(0, 10));
    end
    rnd_mode = 1'b0;
    overflow_clr = 1'b0;
    rx_ready = 1'b1;
    tick(20);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
